// File: rtl/vga_pixel_fetch_if.sv
// Bundle between the VGA timing generator, the framebuffer RAM and the DAC pins.
// Latency: none, wires only.
// Backpressure: none; every signal is a free-running strobe or level.
interface vga_pixel_fetch_if;
  logic        req;
  logic        en;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        hsync_in;
  logic        vsync_in;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  rgb;
  logic        hsync;
  logic        vsync;

  // Generator/RAM/DAC side
  modport master (
    output req, en, col, row, hsync_in, vsync_in, mem_rdata,
    input  mem_rd, mem_addr, rgb, hsync, vsync
  );

  // Pixel fetch block side
  modport slave (
    input  req, en, col, row, hsync_in, vsync_in, mem_rdata,
    output mem_rd, mem_addr, rgb, hsync, vsync
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel source: 160x120 RGB332 scaled 4x4 onto the VGA visible area.
// Latency: fixed 2+MEM_LAT clocks from req to rgb/hsync/vsync, fetched or reused pixel.
// Backpressure: none; req is a free-running strobe and the RAM has fixed read latency.
module vga_pixel_fetch #(
  parameter int         H_START   = 49,
  parameter int         V_START   = 33,
  parameter int         FB_W      = 160,
  parameter int         FB_H      = 120,
  parameter int         MEM_LAT   = 2,     // 1 or 2 only, so a pixel retires before the next strobe
  parameter logic [7:0] BLANK_RGB = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_pixel_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

  state_t state, state_nxt;

  // Two's complement offsets; bit 10 set means left of / above the visible area.
  logic [10:0] dx, dy;
  logic [8:0]  x, y;
  logic [14:0] addr;
  logic        vis;
  logic        fetch;

  // Stage A: request captured one clock after the strobe.
  logic        a_vis, a_fetch, a_hs, a_vs;
  logic [14:0] a_addr;

  // Token marching alongside the RAM read; bit MEM_LAT marks the data-return clock.
  logic [MEM_LAT:0] tok;

  logic        last_valid;
  logic [14:0] last_addr;
  logic [7:0]  last_data;

  // Map the generator position to a framebuffer address and decide whether RAM must be read.
  always_comb begin
    dx    = {1'b0, bus.col} - 11'(H_START);
    dy    = {1'b0, bus.row} - 11'(V_START);
    x     = 9'(dx >> 2);
    y     = 9'(dy >> 2);
    // vsync_in low is never visible: such a pixel is blanked even in RUN.
    vis   = (state == RUN) && bus.en && bus.vsync_in && !dx[10] && !dy[10] &&
            (x < 9'(FB_W)) && (y < 9'(FB_H));
    addr  = 15'(y) * 15'(FB_W) + 15'(x);
    fetch = bus.req && vis && !(last_valid && (addr == last_addr));
  end

  // Frame state: arm on vsync low, start displaying on the vsync trailing edge.
  always_comb begin
    state_nxt = state;
    if (bus.req) begin
      case (state)
        IDLE:    if (!bus.vsync_in) state_nxt = ARM;
        ARM:     if (bus.vsync_in)  state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage A capture and RAM read issue; mem_addr keeps the last address actually read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vis        <= 1'b0;
      a_fetch      <= 1'b0;
      a_hs         <= 1'b1;
      a_vs         <= 1'b1;
      a_addr       <= '0;
      tok          <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      tok        <= {tok[MEM_LAT-1:0], bus.req};
      bus.mem_rd <= fetch;
      if (fetch) bus.mem_addr <= addr;
      if (bus.req) begin
        a_vis   <= vis;
        a_fetch <= fetch;
        a_hs    <= bus.hsync_in;
        a_vs    <= bus.vsync_in;
        a_addr  <= addr;
      end
    end
  end

  // Capture returned RAM data and present colour together with its delayed syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_valid <= 1'b0;
      last_addr  <= '0;
      last_data  <= '0;
      bus.rgb    <= BLANK_RGB;
      bus.hsync  <= 1'b1;
      bus.vsync  <= 1'b1;
    end else begin
      if (tok[MEM_LAT]) begin
        if (a_fetch) begin
          last_data  <= bus.mem_rdata;
          last_addr  <= a_addr;
          last_valid <= 1'b1;
        end
        bus.rgb   <= a_vis ? (a_fetch ? bus.mem_rdata : last_data) : BLANK_RGB;
        bus.hsync <= a_hs;
        bus.vsync <= a_vs;
      end
      // Each vsync forces a fresh read so RAM updates between frames show up.
      if (bus.req && !bus.vsync_in) last_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: one instance per legal MEM_LAT driven with identical stimulus.
// Outputs are compared every clock against a frame-level model and a behavioural RAM.
// Table vectors and hand sequences cover addressing, reuse, vsync and reset corners.
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
  localparam int NRAM = 19200;

  typedef struct { int due; logic [7:0] rgb; logic hs; logic vs; } out_t;
  typedef struct { int due; int addr; } rd_t;
  typedef struct { int col; int row; bit en; bit rd; int addr; logic [7:0] rgb; } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pixel_fetch_if bus1 ();
  vga_pixel_fetch_if bus2 ();

  vga_pixel_fetch #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  vga_pixel_fetch #(.MEM_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic [7:0] ram [NRAM];
  int    cyc = 0, total = 0, bad = 0, rd_cnt = 0, last_req = 0;
  int    c49 = 0, c53 = 0, c688 = 0;
  int    lat [2] = '{1, 2};
  string tag [2] = '{"l1", "l2"};

  // Model state, per instance
  out_t       oq [2][$];
  rd_t        rq [2][$];
  bit         armed [2], running [2], have_last [2];
  int         last_addr [2];
  logic [7:0] e_rgb [2];
  logic       e_hs [2], e_vs [2];

  // RAM read history for the behavioural RAM
  bit rdh_v [2][8];
  int rdh_a [2][8];

  // Observed DUT (MEM_LAT=2) outputs per cycle, for explicit spot checks
  logic       obs_rd   [65536];
  int         obs_addr [65536];
  logic [7:0] obs_rgb  [65536];

  vec_t tv [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      oq[d].delete();
      rq[d].delete();
      armed[d] = 0; running[d] = 0; have_last[d] = 0; last_addr[d] = 0;
      e_rgb[d] = 8'h00; e_hs[d] = 1'b1; e_vs[d] = 1'b1;
    end
  endtask

  // Frame-level behaviour of one pixel request issued in cycle cyc.
  task automatic model_req(input int d, input bit en, input int col, input int row,
                           input bit hs, input bit vs);
    int dx, dy, x, y, a;
    bit vis;
    out_t o;
    rd_t r;
    dx  = col - 49;
    dy  = row - 33;
    x   = dx / 4;
    y   = dy / 4;
    vis = running[d] && en && vs && dx >= 0 && dy >= 0 && x < 160 && y < 120;
    a   = y * 160 + x;
    if (vis && !(have_last[d] && last_addr[d] == a)) begin
      r.due = cyc + 1; r.addr = a;
      rq[d].push_back(r);
      have_last[d] = 1;
      last_addr[d] = a;
    end
    if (!vs) have_last[d] = 0;
    o.due = cyc + 2 + lat[d];
    o.rgb = vis ? ram[a] : 8'h00;
    o.hs  = hs;
    o.vs  = vs;
    oq[d].push_back(o);
    if (!running[d]) begin
      if (armed[d] && vs) running[d] = 1;
      else if (!vs)       armed[d] = 1;
    end
  endtask

  // One clock: observe at the falling edge, feed the RAM, compare, then drive the next inputs.
  task automatic step(input bit rq_i, input bit en, input int col, input int row,
                      input bit hs, input bit vs);
    logic        o_rd, o_hs, o_vs, exp_rd;
    logic [14:0] o_addr;
    logic [7:0]  o_rgb, rdat;
    int          p;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_rd = bus1.mem_rd; o_addr = bus1.mem_addr; o_rgb = bus1.rgb; o_hs = bus1.hsync; o_vs = bus1.vsync;
      end else begin
        o_rd = bus2.mem_rd; o_addr = bus2.mem_addr; o_rgb = bus2.rgb; o_hs = bus2.hsync; o_vs = bus2.vsync;
      end
      rdh_v[d][cyc % 8] = (o_rd === 1'b1);
      rdh_a[d][cyc % 8] = int'(o_addr);
      p = (cyc + 8 - lat[d]) % 8;
      if (rdh_v[d][p] && rdh_a[d][p] < NRAM) rdat = ram[rdh_a[d][p]];
      else                                   rdat = 8'($urandom);
      if (d == 0) bus1.mem_rdata = rdat;
      else        bus2.mem_rdata = rdat;

      while (oq[d].size() > 0 && oq[d][0].due <= cyc) begin
        e_rgb[d] = oq[d][0].rgb; e_hs[d] = oq[d][0].hs; e_vs[d] = oq[d][0].vs;
        void'(oq[d].pop_front());
      end
      chk({"rgb_", tag[d]},   32'(o_rgb), 32'(e_rgb[d]));
      chk({"hsync_", tag[d]}, 32'(o_hs),  32'(e_hs[d]));
      chk({"vsync_", tag[d]}, 32'(o_vs),  32'(e_vs[d]));
      exp_rd = (rq[d].size() > 0 && rq[d][0].due == cyc);
      chk({"mem_rd_", tag[d]}, 32'(o_rd), 32'(exp_rd));
      if (exp_rd) begin
        chk({"mem_addr_", tag[d]}, 32'(o_addr), 32'(rq[d][0].addr));
        void'(rq[d].pop_front());
      end
      while (rq[d].size() > 0 && rq[d][0].due < cyc) void'(rq[d].pop_front());
      if (d == 1) begin
        obs_rd[cyc % 65536]   = o_rd;
        obs_addr[cyc % 65536] = int'(o_addr);
        obs_rgb[cyc % 65536]  = o_rgb;
        if (o_rd === 1'b1) rd_cnt++;
      end
    end
    if (rq_i) begin
      last_req = cyc;
      for (int d = 0; d < 2; d++) model_req(d, en, col, row, hs, vs);
    end
    bus1.req = rq_i; bus1.en = en; bus1.col = 10'(col); bus1.row = 10'(row);
    bus1.hsync_in = hs; bus1.vsync_in = vs;
    bus2.req = rq_i; bus2.en = en; bus2.col = 10'(col); bus2.row = 10'(row);
    bus2.hsync_in = hs; bus2.vsync_in = vs;
  endtask

  // One pixel period: strobe, then three clocks of junk the DUT must ignore.
  task automatic pix(input bit en, input int col, input int row, input bit hs, input bit vs);
    step(1'b1, en, col, row, hs, vs);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
           1'($urandom), 1'($urandom));
  endtask

  task automatic line(input int row, input bit vs, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      pix(c >= 48 && c <= 687, c, row, !((c % 37) < 5), vs);
      if (c == 49)  c49  = last_req;
      if (c == 53)  c53  = last_req;
      if (c == 688) c688 = last_req;
    end
  endtask

  initial begin
    int t, col, row;
    bit en;
    tv[0]  = '{49,   33,   1, 1, 0,     8'h00};
    tv[1]  = '{53,   37,   1, 1, 161,   8'hA1};
    tv[2]  = '{687,  512,  1, 1, 19199, 8'hFF};
    tv[3]  = '{688,  33,   0, 0, 0,     8'h00};
    tv[4]  = '{48,   33,   1, 0, 0,     8'h00};
    tv[5]  = '{49,   32,   1, 0, 0,     8'h00};
    tv[6]  = '{52,   36,   1, 1, 0,     8'h00};
    tv[7]  = '{56,   33,   1, 1, 1,     8'h01};
    tv[8]  = '{689,  100,  1, 0, 0,     8'h00};
    tv[9]  = '{100,  513,  1, 0, 0,     8'h00};
    tv[10] = '{1023, 1023, 1, 0, 0,     8'h00};
    tv[11] = '{100,  100,  0, 0, 0,     8'h00};
    tv[12] = '{400,  300,  1, 1, 10647, 8'h97};

    for (int i = 0; i < NRAM; i++) ram[i] = 8'(i);
    model_reset();
    bus1.req = 0; bus1.en = 0; bus1.col = 0; bus1.row = 0; bus1.hsync_in = 1; bus1.vsync_in = 1; bus1.mem_rdata = 0;
    bus2.req = 0; bus2.en = 0; bus2.col = 0; bus2.row = 0; bus2.hsync_in = 1; bus2.vsync_in = 1; bus2.mem_rdata = 0;

    // Reset state
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("reset_rgb",      32'(bus2.rgb),      32'h00);
    chk("reset_hsync",    32'(bus2.hsync),    32'h1);
    chk("reset_vsync",    32'(bus2.vsync),    32'h1);
    chk("reset_mem_rd",   32'(bus2.mem_rd),   32'h0);
    chk("reset_mem_addr", 32'(bus2.mem_addr), 32'h0);
    rst_n = 1'b1;

    // Frame 0: IDLE, syncs pass through, nothing fetched
    rd_cnt = 0;
    line(33, 1'b1, 0, 99);
    chk("frame0_rd_count", 32'(rd_cnt), 32'd0);
    pix(1'b1, 60, 40, 1'b1, 1'b0);
    pix(1'b0, 0, 500, 1'b1, 1'b0);

    // Frame 1: first full visible line
    rd_cnt = 0;
    line(33, 1'b1, 0, 799);
    chk("line_rd_count",  32'(rd_cnt), 32'd160);
    chk("first_rd",       32'(obs_rd[(c49 + 1) % 65536]),   32'h1);
    chk("first_addr",     32'(obs_addr[(c49 + 1) % 65536]), 32'd0);
    chk("first_rgb",      32'(obs_rgb[(c49 + 4) % 65536]),  32'(ram[0]));
    chk("x1_rgb",         32'(obs_rgb[(c53 + 4) % 65536]),  32'h01);
    chk("col688_rgb",     32'(obs_rgb[(c688 + 4) % 65536]), 32'h00);

    // vsync low while running: blanked, no fetch
    pix(1'b1, 60, 40, 1'b1, 1'b0);
    t = last_req;
    pix(1'b0, 0, 0, 1'b1, 1'b1);
    chk("vslow_rd",  32'(obs_rd[(t + 1) % 65536]), 32'h0);
    chk("vslow_rgb", 32'(obs_rgb[(t + 4) % 65536]), 32'h00);

    // Address table, each vector after a vsync req so it cannot reuse
    for (int i = 0; i < 13; i++) begin
      pix(1'b0, 0, 500, 1'b1, 1'b0);
      pix(tv[i].en, tv[i].col, tv[i].row, 1'b1, 1'b1);
      t = last_req;
      pix(1'b0, 0, 0, 1'b1, 1'b1);
      chk($sformatf("tv%0d_rd", i), 32'(obs_rd[(t + 1) % 65536]), 32'(tv[i].rd));
      if (tv[i].rd) chk($sformatf("tv%0d_addr", i), 32'(obs_addr[(t + 1) % 65536]), 32'(tv[i].addr));
      chk($sformatf("tv%0d_rgb", i), 32'(obs_rgb[(t + 4) % 65536]), 32'(tv[i].rgb));
    end

    // RAM update between frames becomes visible
    pix(1'b0, 0, 500, 1'b1, 1'b0);
    ram[0] = 8'h5A;
    pix(1'b1, 49, 33, 1'b1, 1'b1);
    t = last_req;
    pix(1'b0, 0, 0, 1'b1, 1'b1);
    chk("ram_update_rgb", 32'(obs_rgb[(t + 4) % 65536]), 32'h5A);

    // Randomised traffic, RAM rewritten only right after a vsync req
    col = 0; row = 33;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        pix(1'($urandom), int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) ram[$urandom_range(0, NRAM - 1)] = 8'($urandom);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          col = int'($urandom_range(0, 799));
          row = int'($urandom_range(0, 524));
        end else begin
          col = (col + 1) % 800;
        end
        en = (col >= 48 && col <= 687 && row >= 33 && row <= 512);
        if ($urandom_range(0, 9) == 0) en = !en;
        pix(en, col, row, 1'($urandom_range(0, 7) != 0), 1'b1);
      end
    end

    // Reset while a read is in flight
    pix(1'b0, 0, 500, 1'b1, 1'b0);
    step(1'b1, 1'b1, 100, 200, 1'b1, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("inflight_rd", 32'(bus2.mem_rd), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb",    32'(bus2.rgb),    32'h00);
    chk("arst_hsync",  32'(bus2.hsync),  32'h1);
    chk("arst_vsync",  32'(bus2.vsync),  32'h1);
    chk("arst_mem_rd", 32'(bus2.mem_rd), 32'h0);
    chk("arst_rgb_l1", 32'(bus1.rgb),    32'h00);
    model_reset();
    repeat (3) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    rst_n = 1'b1;
    rd_cnt = 0;
    line(40, 1'b1, 40, 80);
    chk("post_reset_idle_rd", 32'(rd_cnt), 32'd0);
    pix(1'b0, 0, 500, 1'b1, 1'b0);
    pix(1'b0, 0, 501, 1'b1, 1'b0);
    rd_cnt = 0;
    line(41, 1'b1, 40, 80);
    chk("resume_rd_count", 32'(rd_cnt), 32'd8);
    repeat (8) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
